// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   IMEM_SIZE   default instruction memory depth in 32-bit words
//   ST_*        3-bit FSM state encodings and the state_t enum built on them
//   BOUT_*      PC-redirect codes presented to the fetch stage
//   WORD_BYTES  bytes per instruction word
// ---------------------------------------------------------------------------
package imem_loader_pkg;

   localparam int IMEM_SIZE  = 64;
   localparam int WORD_BYTES = 4;

   localparam logic [1:0] BOUT_HOLD = 2'b00;
   localparam logic [1:0] BOUT_JUMP = 2'b01;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RECV    = 3'd1;
   localparam logic [2:0] ST_SETPC   = 3'd2;
   localparam logic [2:0] ST_WRITE   = 3'd3;
   localparam logic [2:0] ST_NEXT    = 3'd4;
   localparam logic [2:0] ST_RESTORE = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_RECV    = ST_RECV,
      S_SETPC   = ST_SETPC,
      S_WRITE   = ST_WRITE,
      S_NEXT    = ST_NEXT,
      S_RESTORE = ST_RESTORE,
      S_DONE    = ST_DONE
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control, byte-stream and fetch-stage signals.
//   start, word_count          load request from the host
//   rx_data, rx_valid, rx_ready byte stream handshake
//   cpu_hold, busy             core stall / load-in-progress indication
//   bout, newPC                PC-redirect request to the fetch stage
//   WE, W_Ins                  IMem write enable and write data
//   done, err                  completion / rejected-start pulses
// Modports: slave = the loader itself, master = the host/fetch-side peer.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int IMEM_SIZE = imem_loader_pkg::IMEM_SIZE
);
   localparam int CW = $clog2(IMEM_SIZE) + 1;

   logic          start;
   logic [CW-1:0] word_count;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          cpu_hold;
   logic [1:0]    bout;
   logic [31:0]   newPC;
   logic          WE;
   logic [31:0]   W_Ins;
   logic          busy;
   logic          done;
   logic          err;

   modport slave (
      input  start, word_count, rx_data, rx_valid,
      output rx_ready, cpu_hold, bout, newPC, WE, W_Ins, busy, done, err
   );

   modport master (
      output start, word_count, rx_data, rx_valid,
      input  rx_ready, cpu_hold, bout, newPC, WE, W_Ins, busy, done, err
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// imem_loader_word_assembler
// Big-endian 8-to-32 shift register with a 2-bit byte counter.
//   CLK          clock
//   RST          synchronous active-low reset
//   clear_i      discard any partial word
//   byte_valid_i a byte is accepted this cycle
//   byte_i       the byte being accepted
//   word_o       current shift register contents
//   word_full_o  the byte accepted this cycle completes a word
// ---------------------------------------------------------------------------
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;

   // Shifting left means the first byte of a word ends up in [31:24].
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (byte_valid_i) begin
         word_d = {word_q[23:0], byte_i};
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   // Combinational so the FSM can leave RECV on the very edge that
   // captures the last byte, without an extra bubble cycle.
   assign word_full_o = byte_valid_i && !clear_i &&
                        (cnt_q == 2'(WORD_BYTES - 1));
   assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a byte stream, assembles big-endian 32-bit instructions and
// writes them into instruction memory through the fetch stage's
// PC-redirect (bout/newPC) and write-enable (WE/W_Ins) inputs, holding the
// core for the whole load and restoring PC to START_PC at the end.
//   CLK   clock, all logic on posedge
//   RST   synchronous active-low reset
//   bus   imem_loader_if.slave: start/word_count request, rx_* byte stream,
//         cpu_hold/busy, bout/newPC, WE/W_Ins, done/err pulses
// ---------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          IMEM_SIZE = imem_loader_pkg::IMEM_SIZE,
   parameter logic [31:0] START_PC  = 32'd0
) (
   input  logic         CLK,
   input  logic         RST,
   imem_loader_if.slave bus
);

   localparam int CW = $clog2(IMEM_SIZE) + 1;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] written_q, written_d;
   logic          err_q, err_d;

   logic          rx_ready;
   logic [1:0]    bout;
   logic [31:0]   new_pc;
   logic          we;
   logic          done;
   logic          byte_accept;
   logic          word_full;
   logic [31:0]   word;
   logic [CW-1:0] written_inc;

   assign byte_accept = bus.rx_valid && rx_ready;
   assign written_inc = written_q + CW'(1);

   imem_loader_word_assembler u_asm (
      .CLK          (CLK),
      .RST          (RST),
      .clear_i      (state_q == S_IDLE),
      .byte_valid_i (byte_accept),
      .byte_i       (bus.rx_data),
      .word_o       (word),
      .word_full_o  (word_full)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      written_d = written_q;
      err_d     = 1'b0;
      rx_ready  = 1'b0;
      bout      = BOUT_HOLD;
      new_pc    = 32'd0;
      we        = 1'b0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if ((bus.word_count == '0) || (bus.word_count > CW'(IMEM_SIZE))) begin
                  err_d = 1'b1;
               end else begin
                  count_d   = bus.word_count;
                  addr_d    = START_PC;
                  written_d = '0;
                  state_d   = S_RECV;
               end
            end
         end
         S_RECV: begin
            rx_ready = 1'b1;
            if (word_full) begin
               state_d = S_SETPC;
            end
         end
         S_SETPC: begin
            bout    = BOUT_JUMP;
            new_pc  = addr_q;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // bout stays HOLD here so the fetch stage writes at the PC
            // it loaded during SETPC.
            we      = 1'b1;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            addr_d    = addr_q + 32'd4;
            written_d = written_inc;
            state_d   = (written_inc == count_q) ? S_RESTORE : S_RECV;
         end
         S_RESTORE: begin
            bout    = BOUT_JUMP;
            new_pc  = START_PC;
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         addr_q    <= START_PC;
         count_q   <= '0;
         written_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         written_q <= written_d;
         err_q     <= err_d;
      end
   end

   assign bus.rx_ready = rx_ready;
   assign bus.cpu_hold = (state_q != S_IDLE);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.bout     = bout;
   assign bus.newPC    = new_pc;
   assign bus.WE       = we;
   assign bus.W_Ins    = word;
   assign bus.done     = done;
   assign bus.err      = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side partner of the instruction-fetch stage's IMem write port.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit instructions (big-endian), and writes them into instruction memory through the fetch stage's PC-redirect and write-enable inputs.
- Holds the core, sequences the PC to each target word address, restores PC to START_PC when finished, then releases the core.
- Sits between a byte source (UART receiver or test host) and the fetch stage.

Parameters:
- IMEM_SIZE, 64, instruction memory depth in 32-bit words; a load may write at most this many words.
- START_PC, 32'd0, byte address of the first word written; PC is restored to this value at the end of a load.
- CW, $clog2(IMEM_SIZE)+1, width of word_count (derived; do not override).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-low reset; RST==0 at a posedge resets the block.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- word_count  in  CW  number of words to load; sampled together with start.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- cpu_hold  out  1  core must stall (no fetch/commit) while 1.
- bout  out  2  PC-redirect request to fetch stage; 2'b01 = load newPC, 2'b00 = hold.
- newPC  out  32  redirect target.
- WE  out  1  IMem write enable; fetch stage writes IMem[PC>>2].
- W_Ins  out  32  instruction word to write.
- busy  out  1  load in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: state IDLE; every output 0; address register = START_PC; byte counter, word counter and shift register cleared.
  - Reset mid-load discards any partial word.
  - Words already written remain in IMem.
- FSM states: IDLE, RECV, SETPC, WRITE, NEXT, RESTORE, DONE.
- IDLE:
  - On start with word_count==0 or word_count>IMEM_SIZE: pulse err for 1 cycle, stay IDLE.
  - On a valid start: latch word_count, set addr=START_PC, go to RECV.
  - start in any other state is ignored.
- RECV:
  - rx_ready=1.
  - Each rx_valid&rx_ready shifts in one byte. The first byte of a word lands in W_Ins[31:24]; the fourth lands in [7:0].
  - After the fourth accepted byte, go to SETPC. No byte is accepted outside RECV.
- SETPC:
  - Hold for 1 cycle with bout=2'b01, newPC=addr, WE=0.
  - The fetch stage loads PC=addr at the end of this cycle.
- WRITE:
  - Hold for 1 cycle with bout=2'b00, WE=1, W_Ins stable.
  - The fetch stage writes IMem[addr>>2].
  - WE must never be 1 in the same cycle as bout!=0.
- NEXT:
  - Hold for 1 cycle; addr+=4 (32-bit wrap is irrelevant because the count is bounded) and increment words_written.
  - If words_written==word_count, go to RESTORE; otherwise go to RECV.
- RESTORE: hold for 1 cycle with bout=2'b01, newPC=START_PC.
- DONE: hold for 1 cycle with done=1 and cpu_hold=1; next cycle go to IDLE with cpu_hold=0.
- cpu_hold: 1 in every state except IDLE, asserted from the cycle after an accepted start.
- busy equals cpu_hold.
- Per-word latency: 4 byte-accept cycles (minimum) + 3 cycles (SETPC, WRITE, NEXT).
  - Minimum total for N words: 7N + 2 cycles after start, including RESTORE and DONE.
- rx_valid with rx_ready=0 is back-pressure; the byte source holds rx_data.
- Outside SETPC/RESTORE, bout=0 and newPC=0.
- Outside WRITE, WE=0. W_Ins may show the shift register contents.

Decomposition:
- Shared package (extends common_param):
  - IMEM_SIZE.
  - FSM state encodings (3-bit localparams).
  - BOUT_HOLD=2'b00, BOUT_JUMP=2'b01.
  - WORD_BYTES=4.
- One sub-module, word_assembler:
  - 8-to-32 big-endian shift register plus a 2-bit byte counter.
  - Inputs: clear, byte strobe.
  - Outputs: word and a word_full flag.
- The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Reset: hold RST=0 for 2 cycles mid-RECV after 2 bytes → all outputs 0, state IDLE. A subsequent load of 1 word 0x20080005 writes only that word; the partial word is never written.
- Single word: start, word_count=1, bytes 0x8C,0x01,0x00,0x04 → SETPC newPC=0, then WRITE with WE=1 and W_Ins=0x8C010004. Then RESTORE with newPC=0, then done pulse exactly 9 cycles after start with no back-pressure.
- Multi-word with back-pressure: word_count=3, rx_valid toggling every other cycle → writes at addresses 0x0, 0x4, 0x8 in order with correct words. No byte is lost or duplicated; rx_ready=0 in every non-RECV cycle.
- Errors: start with word_count=0, then start with word_count=65 (IMEM_SIZE=64) → err pulses for 1 cycle each. cpu_hold, WE and bout stay 0.
- Full memory: word_count=64 → last write at addr 0xFC. done fires; never WE=1 with bout!=0. cpu_hold drops the cycle after done.
- Start while busy: pulse start during RECV of word 2 → ignored; the load completes with the original count and START_PC is restored.
